// File: rtl/regfile_pkg.sv
// Shared register-file constants and a small index helper used by the write arbiter.
package regfile_pkg;

    localparam int REG_NUM = 32;
    localparam int REG_AW  = 5;
    localparam int REG_DW  = 32;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 == n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/regfile_wr_arb_rr_arbiter.sv
// N-wide round-robin arbiter: the search starts at the pointer, and the pointer moves past the winner.
module rr_arbiter
    import regfile_pkg::*;
#(
    parameter int N = 3,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic          found;
    int            idx;

    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int o = 0; o < N; o++) begin
            idx = (int'(ptr_q) + o) % N;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                ptr_d    = PW'(wrap_inc(idx, N));
            end
        end
        // A request cannot be consumed while reset is asserted.
        if (reset) begin
            gnt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_wr_arb.sv
// Round-robin sharing of the register-file write port, with a pending-write scoreboard for RAW stalls.
// Optional forwarding from the write register is enabled by defining REGFILE_WR_ARB_FWD_EN.
module regfile_wr_arb
    import regfile_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int AW   = REG_AW,
    parameter int DW   = REG_DW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic                 wen,
    output logic [AW-1:0]        waddr,
    output logic [DW-1:0]        wdata,
    input  logic                 sb_set_valid,
    input  logic [AW-1:0]        sb_set_addr,
    input  logic [AW-1:0]        raddr1,
    input  logic [AW-1:0]        raddr2,
    output logic                 stall,
    output logic [REG_NUM-1:0]   pending,
`ifdef REGFILE_WR_ARB_FWD_EN
    output logic                 fwd1_hit,
    output logic                 fwd2_hit,
    output logic [DW-1:0]        fwd1_data,
    output logic [DW-1:0]        fwd2_data,
`endif
    output logic [15:0]          drop_cnt
);

    logic               wen_q, wen_d;
    logic [AW-1:0]      waddr_q, waddr_d;
    logic [DW-1:0]      wdata_q, wdata_d;
    logic [REG_NUM-1:0] pending_q, pending_d;
    logic [15:0]        drop_q, drop_d;
    logic [AW-1:0]      sel_addr;
    logic [DW-1:0]      sel_data;
    logic               any_gnt;

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req_valid),
        .gnt   (req_ready)
    );

    always_comb begin
        sel_addr  = '0;
        sel_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*DW +: DW];
            end
        end
        any_gnt = |req_ready;
        wen_d   = any_gnt && (sel_addr != AW'(REG_ZERO));
        waddr_d = wen_d ? sel_addr : waddr_q;
        wdata_d = wen_d ? sel_data : wdata_q;

        drop_d = drop_q;
        if (any_gnt && (sel_addr == AW'(REG_ZERO)) && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end

        // Set is applied after clear so a newer producer keeps the register pending.
        pending_d = pending_q;
        if (wen_d) begin
            pending_d[sel_addr] = 1'b0;
        end
        if (sb_set_valid && (sb_set_addr != AW'(REG_ZERO))) begin
            pending_d[sb_set_addr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wen_q     <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            pending_q <= '0;
            drop_q    <= '0;
        end else begin
            wen_q     <= wen_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            pending_q <= pending_d;
            drop_q    <= drop_d;
        end
    end

    assign wen      = wen_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign pending  = pending_q;
    assign drop_cnt = drop_q;

`ifdef REGFILE_WR_ARB_FWD_EN
    always_comb begin
        fwd1_hit  = wen_q && (raddr1 != AW'(REG_ZERO)) && (waddr_q == raddr1);
        fwd2_hit  = wen_q && (raddr2 != AW'(REG_ZERO)) && (waddr_q == raddr2);
        fwd1_data = wdata_q;
        fwd2_data = wdata_q;
        stall = ((raddr1 != AW'(REG_ZERO)) && pending_q[raddr1] && !fwd1_hit) ||
                ((raddr2 != AW'(REG_ZERO)) && pending_q[raddr2] && !fwd2_hit);
    end
`else
    always_comb begin
        stall = ((raddr1 != AW'(REG_ZERO)) && pending_q[raddr1]) ||
                ((raddr2 != AW'(REG_ZERO)) && pending_q[raddr2]);
    end
`endif

endmodule

// File: tb/tb_regfile_wr_arb.sv
// Directed vector bench for regfile_wr_arb (default build, forwarding disabled).
module tb_regfile_wr_arb;

    localparam logic [31:0] D0 = 32'hDEADBEEF;
    localparam logic [31:0] D1 = 32'h1111_2222;
    localparam logic [31:0] D2 = 32'h3333_4444;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        sb_set_valid;
    logic [4:0]  sb_set_addr;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic        stall;
    logic [31:0] pending;
    logic [15:0] drop_cnt;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    regfile_wr_arb dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .wen          (wen),
        .waddr        (waddr),
        .wdata        (wdata),
        .sb_set_valid (sb_set_valid),
        .sb_set_addr  (sb_set_addr),
        .raddr1       (raddr1),
        .raddr2       (raddr2),
        .stall        (stall),
        .pending      (pending),
        .drop_cnt     (drop_cnt)
    );

    typedef struct {
        logic        rst;
        logic [2:0]  valid;
        logic [4:0]  a0, a1, a2;
        logic        set;
        logic [4:0]  set_a, r1, r2;
        logic [2:0]  e_rdy;
        logic        e_stall;
        logic        e_wen;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        logic [31:0] e_pend;
        logic [15:0] e_drop;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic [2:0] valid,
                       input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                       input logic set, input logic [4:0] set_a,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic [2:0] e_rdy, input logic e_stall,
                       input logic e_wen, input logic [4:0] e_waddr, input logic [31:0] e_wdata,
                       input logic [31:0] e_pend, input logic [15:0] e_drop);
        vec_t v;
        v.rst = rst; v.valid = valid; v.a0 = a0; v.a1 = a1; v.a2 = a2;
        v.set = set; v.set_a = set_a; v.r1 = r1; v.r2 = r2;
        v.e_rdy = e_rdy; v.e_stall = e_stall; v.e_wen = e_wen;
        v.e_waddr = e_waddr; v.e_wdata = e_wdata; v.e_pend = e_pend; v.e_drop = e_drop;
        tbl.push_back(v);
    endtask

    task automatic chk(input int idx, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL vec %0d %s: got %h expected %h", idx, name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset        = v.rst;
        req_valid    = v.valid;
        req_addr     = {v.a2, v.a1, v.a0};
        req_data     = {D2, D1, D0};
        sb_set_valid = v.set;
        sb_set_addr  = v.set_a;
        raddr1       = v.r1;
        raddr2       = v.r2;
    endtask

    initial begin
        reset = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;
        sb_set_valid = 1'b0; sb_set_addr = '0; raddr1 = '0; raddr2 = '0;

        // rst valid  a0 a1 a2 set sa r1 r2 | rdy   stall wen waddr wdata pend          drop
        add(1, 3'b111, 1, 2, 3, 0, 0, 0, 0, 3'b000, 0, 0, 0, 32'h0, 32'h0,          0);
        add(1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 32'h0, 32'h0,          0);
        add(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 32'h0, 32'h0,          0);
        add(0, 3'b001, 5, 0, 0, 0, 0, 0, 0, 3'b001, 0, 1, 5, D0,    32'h0,          0);
        add(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 5, D0,    32'h0,          0);
        add(0, 3'b100, 0, 0, 9, 0, 0, 0, 0, 3'b100, 0, 1, 9, D2,    32'h0,          0);
        add(0, 3'b111, 1, 2, 3, 0, 0, 0, 0, 3'b001, 0, 1, 1, D0,    32'h0,          0);
        add(0, 3'b111, 1, 2, 3, 0, 0, 0, 0, 3'b010, 0, 1, 2, D1,    32'h0,          0);
        add(0, 3'b111, 1, 2, 3, 0, 0, 0, 0, 3'b100, 0, 1, 3, D2,    32'h0,          0);
        add(0, 3'b111, 1, 2, 3, 0, 0, 0, 0, 3'b001, 0, 1, 1, D0,    32'h0,          0);
        add(0, 3'b111, 1, 2, 3, 0, 0, 0, 0, 3'b010, 0, 1, 2, D1,    32'h0,          0);
        add(0, 3'b111, 1, 2, 3, 0, 0, 0, 0, 3'b100, 0, 1, 3, D2,    32'h0,          0);
        add(0, 3'b110, 0, 2, 3, 0, 0, 0, 0, 3'b010, 0, 1, 2, D1,    32'h0,          0);
        add(0, 3'b011, 4, 6, 0, 0, 0, 0, 0, 3'b001, 0, 1, 4, D0,    32'h0,          0);
        add(0, 3'b010, 0, 0, 0, 0, 0, 0, 0, 3'b010, 0, 0, 4, D0,    32'h0,          1);
        add(0, 3'b010, 0, 0, 0, 0, 0, 0, 0, 3'b010, 0, 0, 4, D0,    32'h0,          2);
        add(0, 3'b010, 0, 0, 0, 0, 0, 0, 0, 3'b010, 0, 0, 4, D0,    32'h0,          3);
        add(0, 3'b000, 0, 0, 0, 1, 7, 7, 0, 3'b000, 0, 0, 4, D0,    32'h0000_0080,  3);
        add(0, 3'b000, 0, 0, 0, 0, 0, 7, 0, 3'b000, 1, 0, 4, D0,    32'h0000_0080,  3);
        add(0, 3'b000, 0, 0, 0, 1, 0, 0, 0, 3'b000, 0, 0, 4, D0,    32'h0000_0080,  3);
        add(0, 3'b001, 7, 0, 0, 0, 0, 0, 7, 3'b001, 1, 1, 7, D0,    32'h0,          3);
        add(0, 3'b000, 0, 0, 0, 0, 0, 0, 7, 3'b000, 0, 0, 7, D0,    32'h0,          3);
        add(0, 3'b001, 7, 0, 0, 1, 7, 0, 0, 3'b001, 0, 1, 7, D0,    32'h0000_0080,  3);
        add(0, 3'b001, 7, 0, 0, 1, 3, 7, 0, 3'b001, 1, 1, 7, D0,    32'h0000_0008,  3);
        add(0, 3'b010, 0, 6, 0, 1, 7, 3, 7, 3'b010, 1, 1, 6, D1,    32'h0000_0088,  3);
        add(1, 3'b111, 1, 2, 3, 1, 5, 3, 7, 3'b000, 1, 0, 0, 32'h0, 32'h0,          0);
        add(0, 3'b111, 1, 2, 3, 0, 0, 3, 7, 3'b001, 0, 1, 1, D0,    32'h0,          0);

        @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            drive(tbl[i]);
            #3;
            chk(i, "req_ready", 32'(req_ready), 32'(tbl[i].e_rdy));
            chk(i, "stall",     32'(stall),     32'(tbl[i].e_stall));
            @(posedge clk);
            #1;
            chk(i, "wen",      32'(wen),      32'(tbl[i].e_wen));
            chk(i, "waddr",    32'(waddr),    32'(tbl[i].e_waddr));
            chk(i, "wdata",    wdata,         tbl[i].e_wdata);
            chk(i, "pending",  pending,       tbl[i].e_pend);
            chk(i, "drop_cnt", 32'(drop_cnt), 32'(tbl[i].e_drop));
        end

        // Requester 2 held valid behind two competitors must be granted within NREQ cycles.
        begin
            bit got = 1'b0;
            reset = 1'b0; sb_set_valid = 1'b0;
            req_valid = 3'b111;
            req_addr  = {5'd12, 5'd11, 5'd10};
            for (int c = 0; c < 3 && !got; c++) begin
                #3;
                if (req_ready[2]) got = 1'b1;
                @(posedge clk);
                #1;
            end
            chk(100, "req2_granted_in_budget", 32'(got), 32'd1);
            chk(100, "req2_waddr", 32'(waddr), 32'd12);
            chk(100, "req2_wdata", wdata, D2);
            req_valid = 3'b000;
            @(posedge clk);
            #1;
            chk(101, "idle_wen", 32'(wen), 32'd0);
            chk(101, "idle_waddr_hold", 32'(waddr), 32'd12);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
